// File: rtl/mem_definitions_pkg.sv
// Shared memory-access types and helpers for the memory arbiter.
//   mem_mask_t  : access width/extension type (funct3-style encoding)
//   arb_state_t : arbiter FSM states
//   grant_t     : data-access attributes latched at grant time
//   mem_be_f    : byte enables for an access type and byte offset
//   mem_misaligned_f : misalignment test for an access type and byte offset
package mem_definitions;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [2:0] {
    MASK_BYTE  = 3'b000,
    MASK_HALF  = 3'b001,
    MASK_WORD  = 3'b010,
    MASK_UBYTE = 3'b100,
    MASK_UHALF = 3'b101
  } mem_mask_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_D,
    ARB_GRANT_IF,
    ARB_RESP
  } arb_state_t;

  typedef struct packed {
    logic      we;
    mem_mask_t mask;
    logic [1:0] off;
  } grant_t;

  function automatic logic [BE_W-1:0] mem_be_f(input mem_mask_t mask, input logic [1:0] off);
    logic [BE_W-1:0] be;
    case (mask)
      MASK_BYTE, MASK_UBYTE: be = 4'b0001 << off;
      MASK_HALF, MASK_UHALF: be = 4'b0011 << {off[1], 1'b0};
      MASK_WORD:             be = 4'b1111;
      default:               be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic mem_misaligned_f(input mem_mask_t mask, input logic [1:0] off);
    logic mis;
    case (mask)
      MASK_HALF, MASK_UHALF: mis = off[0];
      MASK_WORD:             mis = (off != 2'b00);
      default:               mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering between the core and a 32-bit byte-enabled bus.
//   st_mask/st_off/st_wdata : store access type, byte offset, right-justified data
//   st_be_c/st_wdata_c      : byte enables and lane-replicated store data
//   ld_mask/ld_off/ld_rdata : load access type, byte offset, raw bus word
//   ld_rdata_c              : shifted and sign/zero-extended load data
module mem_lane_align
  import mem_definitions::*;
(
  input  mem_mask_t         st_mask,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_wdata,
  input  mem_mask_t         ld_mask,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [BE_W-1:0]   st_be_c,
  output logic [DATA_W-1:0] st_wdata_c,
  output logic [DATA_W-1:0] ld_rdata_c
);

  logic [DATA_W-1:0] ld_shifted;

  // Store: replicate into every lane; the byte enables pick the live one.
  always_comb begin
    st_be_c    = mem_be_f(st_mask, st_off);
    st_wdata_c = st_wdata;
    case (st_mask)
      MASK_BYTE, MASK_UBYTE: st_wdata_c = {4{st_wdata[7:0]}};
      MASK_HALF, MASK_UHALF: st_wdata_c = {2{st_wdata[15:0]}};
      default:               st_wdata_c = st_wdata;
    endcase
  end

  // Load: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    ld_rdata_c = ld_shifted;
    case (ld_mask)
      MASK_BYTE:  ld_rdata_c = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      MASK_UBYTE: ld_rdata_c = {24'h000000, ld_shifted[7:0]};
      MASK_HALF:  ld_rdata_c = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      MASK_UHALF: ld_rdata_c = {16'h0000, ld_shifted[15:0]};
      default:    ld_rdata_c = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and data access.
// Data has priority; after MAX_DATA_BURST data grants with a fetch pending, fetch is forced.
//   clk, rst                         : clock, async active-high reset
//   if_req/if_addr/if_rdata/if_ack   : fetch port
//   d_read/d_write/d_addr/d_wdata/d_mask/d_rdata/d_ack/d_err : data port
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be/mem_rdata/mem_ready : bus
//   stall_if, stall_mem              : per-stage stall (combinational)
module mem_arbiter
  import mem_definitions::*;
#(
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_mask,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned CNT_W = $clog2(MAX_DATA_BURST + 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  grant_t            grant_q, grant_d;

  logic              mem_req_d, mem_we_d, if_ack_d, d_ack_d, d_err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, d_rdata_d;
  logic [BE_W-1:0]   mem_be_d;

  mem_mask_t         d_mask_e;
  logic              d_any, forced;
  logic [BE_W-1:0]   st_be_c;
  logic [DATA_W-1:0] st_wdata_c, ld_rdata_c;
  logic              unused_if_addr_lsb;

  assign d_mask_e           = mem_mask_t'(d_mask);
  assign d_any              = d_read | d_write;
  assign forced             = if_req && (count_q == CNT_W'(MAX_DATA_BURST));
  assign unused_if_addr_lsb = ^if_addr[1:0];

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_any & ~d_ack;

  // Store side looks at the live request; load side at the access latched at grant.
  mem_lane_align u_lane (
    .st_mask   (d_mask_e),
    .st_off    (d_addr[1:0]),
    .st_wdata  (d_wdata),
    .ld_mask   (grant_q.mask),
    .ld_off    (grant_q.off),
    .ld_rdata  (mem_rdata),
    .st_be_c   (st_be_c),
    .st_wdata_c(st_wdata_c),
    .ld_rdata_c(ld_rdata_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    grant_d     = grant_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = mem_be;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (!if_req) count_d = '0;
        if (d_any && !forced) begin
          // A simultaneous read+write is treated as a store.
          grant_d = '{we: d_write, mask: d_mask_e, off: d_addr[1:0]};
          if (if_req && (count_q != CNT_W'(MAX_DATA_BURST))) count_d = count_q + CNT_W'(1);
          if (mem_misaligned_f(d_mask_e, d_addr[1:0])) begin
            state_d   = ARB_RESP;
            d_ack_d   = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            state_d     = ARB_GRANT_D;
            mem_req_d   = 1'b1;
            mem_we_d    = d_write;
            mem_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = st_wdata_c;
            mem_be_d    = st_be_c;
          end
        end else if (if_req) begin
          count_d     = '0;
          state_d     = ARB_GRANT_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = '0;
          mem_be_d    = 4'b1111;
        end
      end
      ARB_GRANT_D: begin
        if (mem_ready) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = '0;
          d_ack_d   = 1'b1;
          d_rdata_d = grant_q.we ? '0 : ld_rdata_c;
        end
      end
      ARB_GRANT_IF: begin
        if (mem_ready) begin
          state_d    = ARB_RESP;
          mem_req_d  = 1'b0;
          mem_be_d   = '0;
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // State, grant latch, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      count_q   <= '0;
      grant_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      grant_q   <= grant_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_be    <= mem_be_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
      if_ack    <= if_ack_d;
      d_ack     <= d_ack_d;
      d_err     <= d_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected bus grants and acks,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_arbiter;
  import mem_definitions::*;

  localparam int K_BUS  = 0;
  localparam int K_IACK = 1;
  localparam int K_DACK = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata;
  logic [2:0]  d_mask;
  logic [31:0] d_rdata;
  logic        d_ack, d_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if, stall_mem;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   ready_lat = 0;
  int   wait_cnt = 0;
  logic [31:0] rd_value = '0;
  logic prev_req = 1'b0;

  mem_arbiter #(.MAX_DATA_BURST(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_mask(d_mask), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata);
    exp_t e;
    e.kind = K_BUS; e.addr = addr; e.we = we; e.be = be; e.data = wdata; e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_ack(input int kind, input logic [31:0] data, input logic err);
    exp_t e;
    e.kind = kind; e.addr = '0; e.we = 1'b0; e.be = '0; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      if (kind == K_BUS) begin
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_be", 32'(mem_be), 32'(e.be));
        chk("mem_wdata", mem_wdata, e.data);
      end else if (kind == K_IACK) begin
        chk("if_rdata", if_rdata, e.data);
      end else begin
        chk("d_rdata", d_rdata, e.data);
        chk("d_err", 32'(d_err), 32'(e.err));
      end
    end
  endtask

  // Monitor: compare every grant and every ack against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && !prev_req) pop_check(K_BUS);
      if (if_ack) pop_check(K_IACK);
      if (d_ack) pop_check(K_DACK);
      assert (!(d_read && d_write)) else $error("FAIL illegal_rw: d_read and d_write both high");
    end
    prev_req <= mem_req;
  end

  // Bus responder: mem_ready after ready_lat cycles of mem_req.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !mem_ready) begin
        if (wait_cnt >= ready_lat) begin
          mem_ready = 1'b1;
          mem_rdata = rd_value;
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  task automatic do_data(input logic wr, input logic [31:0] addr, input logic [2:0] mask,
                         input logic [31:0] wdata, output int lat);
    @(posedge clk); #1;
    d_read = ~wr; d_write = wr; d_addr = addr; d_mask = mask; d_wdata = wdata;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (d_ack) break;
    end
    if (!d_ack) begin
      checks++; errors++;
      $display("FAIL d_ack_timeout: got no ack expected ack within 100 cycles");
    end
    d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] addr, output int lat);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = addr;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (if_ack) break;
    end
    if (!if_ack) begin
      checks++; errors++;
      $display("FAIL if_ack_timeout: got no ack expected ack within 100 cycles");
    end
    if_req = 1'b0;
  endtask

  initial begin
    int lat_a, lat_b, n;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_mask = MASK_WORD;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_d_err", 32'(d_err), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Fetch only, zero-wait bus
    ready_lat = 0; rd_value = 32'h00500093;
    push_bus(32'h100, 1'b0, 4'b1111, 32'h0);
    push_ack(K_IACK, 32'h00500093, 1'b0);
    do_fetch(32'h100, lat_a);
    chk("fetch_latency", 32'(lat_a), 32'd2);

    // Simultaneous requests: data first, fetch after d_ack
    rd_value = 32'h11223344;
    push_bus(32'h200, 1'b0, 4'b1111, 32'h0);
    push_ack(K_DACK, 32'h11223344, 1'b0);
    push_bus(32'h100, 1'b0, 4'b1111, 32'h0);
    push_ack(K_IACK, 32'h11223344, 1'b0);
    fork
      do_data(1'b0, 32'h200, MASK_WORD, 32'h0, lat_a);
      do_fetch(32'h100, lat_b);
    join
    chk("both_data_latency", 32'(lat_a), 32'd2);
    chk("both_fetch_latency", 32'(lat_b), 32'd5);

    // Sub-word loads
    rd_value = 32'h80FFFFFF;
    push_bus(32'h200, 1'b0, 4'b1000, 32'h0);
    push_ack(K_DACK, 32'hFFFFFF80, 1'b0);
    do_data(1'b0, 32'h203, MASK_BYTE, 32'h0, lat_a);
    push_bus(32'h200, 1'b0, 4'b1000, 32'h0);
    push_ack(K_DACK, 32'h00000080, 1'b0);
    do_data(1'b0, 32'h203, MASK_UBYTE, 32'h0, lat_a);
    ready_lat = 2;
    push_bus(32'h200, 1'b0, 4'b1100, 32'h0);
    push_ack(K_DACK, 32'hFFFF80FF, 1'b0);
    do_data(1'b0, 32'h202, MASK_HALF, 32'h0, lat_a);
    chk("wait_state_latency", 32'(lat_a), 32'd4);
    ready_lat = 0; rd_value = 32'h1234ABCD;
    push_bus(32'h200, 1'b0, 4'b0011, 32'h0);
    push_ack(K_DACK, 32'h0000ABCD, 1'b0);
    do_data(1'b0, 32'h200, MASK_UHALF, 32'h0, lat_a);

    // Stores
    push_bus(32'h300, 1'b1, 4'b1100, 32'hABCDABCD);
    push_ack(K_DACK, 32'h0, 1'b0);
    do_data(1'b1, 32'h302, MASK_HALF, 32'h1234ABCD, lat_a);
    push_bus(32'h300, 1'b1, 4'b0010, 32'h55555555);
    push_ack(K_DACK, 32'h0, 1'b0);
    do_data(1'b1, 32'h301, MASK_BYTE, 32'h00000055, lat_a);
    push_bus(32'h304, 1'b1, 4'b1111, 32'hA5A50F0F);
    push_ack(K_DACK, 32'h0, 1'b0);
    do_data(1'b1, 32'h304, MASK_WORD, 32'hA5A50F0F, lat_a);

    // Misaligned: no bus cycle, error ack next cycle
    push_ack(K_DACK, 32'h0, 1'b1);
    do_data(1'b0, 32'h201, MASK_WORD, 32'h0, lat_a);
    chk("misaligned_latency", 32'(lat_a), 32'd1);
    push_ack(K_DACK, 32'h0, 1'b1);
    do_data(1'b1, 32'h303, MASK_HALF, 32'h0, lat_a);

    // Starvation: continuous data + fetch gives 4 data grants then 1 fetch
    rd_value = 32'hCAFEF00D;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        push_bus(32'h400, 1'b0, 4'b1111, 32'h0);
        push_ack(K_DACK, 32'hCAFEF00D, 1'b0);
      end
      push_bus(32'h100, 1'b0, 4'b1111, 32'h0);
      push_ack(K_IACK, 32'hCAFEF00D, 1'b0);
    end
    @(posedge clk); #1;
    d_read = 1'b1; d_addr = 32'h400; d_mask = MASK_WORD; d_wdata = '0;
    if_req = 1'b1; if_addr = 32'h100;
    n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(posedge clk); #1;
      if (d_ack || if_ack) n++;
    end
    d_read = 1'b0; if_req = 1'b0;
    chk("burst_ack_count", 32'(n), 32'd10);

    // Reset while the bus is waiting: mem_req drops at once, no ack
    ready_lat = 1000;
    push_bus(32'h500, 1'b0, 4'b1111, 32'h0);
    @(posedge clk); #1;
    d_read = 1'b1; d_addr = 32'h500; d_mask = MASK_WORD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall_mem_waiting", 32'(stall_mem), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_d_ack", 32'(d_ack), 32'd0);
    d_read = 1'b0;
    #1;
    chk("stall_mem_idle", 32'(stall_mem), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    ready_lat = 0;
    repeat (5) @(posedge clk);

    // Recovery fetch; low address bits are ignored
    rd_value = 32'hDEADBEEF;
    push_bus(32'h104, 1'b0, 4'b1111, 32'h0);
    push_ack(K_IACK, 32'hDEADBEEF, 1'b0);
    do_fetch(32'h107, lat_a);
    chk("recovery_fetch_latency", 32'(lat_a), 32'd2);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
